// File: rtl/bck_store_arbiter_pkg.sv
// Shared definitions for the backward-extension store path: status codes,
// store-entry layout and write-region select values.
package bck_pkg;

  localparam logic [5:0] F_init   = 6'h1;
  localparam logic [5:0] F_run    = 6'h2;
  localparam logic [5:0] F_break  = 6'h3;
  localparam logic [5:0] BCK_INI  = 6'h4;
  localparam logic [5:0] BCK_RUN  = 6'h5;
  localparam logic [5:0] BCK_END  = 6'h6;
  localparam logic [5:0] DONE     = 6'h7;
  localparam logic [5:0] BUBBLE   = 6'h30;

  localparam logic WR_SEL_MEM  = 1'b0;
  localparam logic WR_SEL_CURR = 1'b1;

  localparam int ST_ADDR_W = 7;
  localparam int ST_DATA_W = 64;

  typedef struct packed {
    logic                 sel;
    logic [ST_ADDR_W-1:0] addr;
    logic [ST_DATA_W-1:0] x0;
    logic [ST_DATA_W-1:0] x1;
    logic [ST_DATA_W-1:0] x2;
    logic [ST_DATA_W-1:0] info;
  } store_entry_t;

  localparam int STORE_ENTRY_W = $bits(store_entry_t);

  // Entry width for non-default address/data widths; field order matches store_entry_t.
  function automatic int entry_width(input int aw, input int dw);
    return 1 + aw + 4 * dw;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} drain_state_t;

endpackage

// File: rtl/bck_store_arbiter_if.sv
// Store-request streams from the backward-extension stage and the token RAM
// write port; master is the upstream/RAM side, slave is the arbiter.
interface bck_store_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
);
  logic              store_valid_mem;
  logic [DATA_W-1:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
  logic [ADDR_W-1:0] mem_x_addr;
  logic              store_valid_curr;
  logic [DATA_W-1:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
  logic [ADDR_W-1:0] curr_x_addr;

  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_x0, wr_x1, wr_x2, wr_info;

  modport master (
    output store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    output store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    input  wr_en, wr_sel, wr_addr, wr_x0, wr_x1, wr_x2, wr_info
  );

  modport slave (
    input  store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    input  store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    output wr_en, wr_sel, wr_addr, wr_x0, wr_x1, wr_x2, wr_info
  );
endinterface

// File: rtl/bck_store_arbiter_fifo.sv
// Dual-push / single-pop FIFO; push0 lands ahead of push1 in the same cycle.
module bck_store_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  logic [W-1:0]             din0,
  input  logic                     push1,
  input  logic [W-1:0]             din1,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, wptr1;
  logic [CW-1:0] count_q, count_d;
  logic          ok0, ok1, okp;

  // Space check ignores a same-cycle pop, so a full FIFO never accepts a push.
  always_comb begin
    ok0     = push0 && (count_q < CW'(DEPTH));
    ok1     = push1 && ((count_q + CW'(ok0)) < CW'(DEPTH));
    okp     = pop && (count_q != '0);
    wptr1   = tail_q + PW'(ok0);
    tail_d  = tail_q + PW'(ok0) + PW'(ok1);
    head_d  = head_q + PW'(okp);
    count_d = count_q + CW'(ok0) + CW'(ok1) - CW'(okp);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ok0) mem_q[tail_q] <= din0;
    if (ok1) mem_q[wptr1]  <= din1;
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/bck_store_arbiter.sv
// Serialises mem/curr token stores onto the single token-RAM write port,
// throttles upstream with a registered stall and tracks per-iteration drain.
module bck_store_arbiter
  import bck_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        status_q,
  bck_store_if.slave        st_if,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_wr_cnt,
  output logic [ADDR_W-1:0] curr_wr_cnt,
  output logic              flush_done
);
  localparam int EW = entry_width(ADDR_W, DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic              stall_q, stall_d;
  logic              wr_en_q;
  logic [EW-1:0]     wr_q;
  logic [ADDR_W-1:0] mem_cnt_q, mem_cnt_d, curr_cnt_q, curr_cnt_d;
  drain_state_t      state_q, state_d;

  logic              accept, push_mem, push_curr, pop, is_ini, is_end, fifo_empty;
  logic [EW-1:0]     mem_entry, curr_entry, head;
  logic [CW-1:0]     occ;
  logic [OW-1:0]     occ_next;

  assign accept    = !stall_q;
  assign push_mem  = accept && st_if.store_valid_mem;
  assign push_curr = accept && st_if.store_valid_curr;
  assign is_ini    = accept && (status_q == BCK_INI);
  assign is_end    = accept && (status_q == BCK_END);
  assign pop       = !fifo_empty;

  assign mem_entry  = {WR_SEL_MEM, st_if.mem_x_addr, st_if.mem_x_0, st_if.mem_x_1,
                       st_if.mem_x_2, st_if.mem_x_info};
  assign curr_entry = {WR_SEL_CURR, st_if.curr_x_addr, st_if.curr_x_0, st_if.curr_x_1,
                       st_if.curr_x_2, st_if.curr_x_info};

  bck_store_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push_mem),
    .din0  (mem_entry),
    .push1 (push_curr),
    .din1  (curr_entry),
    .pop   (pop),
    .dout  (head),
    .count (occ),
    .empty (fifo_empty)
  );

  // Stalling above DEPTH-2 leaves room for a dual push in every accepted cycle.
  always_comb begin
    occ_next = OW'(occ) + OW'(push_mem) + OW'(push_curr) - OW'(pop);
    stall_d  = (occ_next > OW'(FIFO_DEPTH - 2));
  end

  always_comb begin
    mem_cnt_d  = mem_cnt_q;
    curr_cnt_d = curr_cnt_q;
    if (is_ini) begin
      mem_cnt_d  = '0;
      curr_cnt_d = '0;
    end else if (wr_en_q) begin
      if (wr_q[EW-1] == WR_SEL_CURR) begin
        if (curr_cnt_q != '1) curr_cnt_d = curr_cnt_q + 1'b1;
      end else begin
        if (mem_cnt_q != '1) mem_cnt_d = mem_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      S_IDLE:  if (is_ini) state_d = S_RUN;
      S_RUN:   if (is_end) state_d = S_DRAIN;
      S_DRAIN: begin
        if (is_ini) begin
          state_d = S_RUN;
        end else if (fifo_empty && !wr_en_q) begin
          state_d    = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_q       <= '0;
      mem_cnt_q  <= '0;
      curr_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      stall_q    <= stall_d;
      wr_en_q    <= pop;
      if (pop) wr_q <= head;
      mem_cnt_q  <= mem_cnt_d;
      curr_cnt_q <= curr_cnt_d;
      state_q    <= state_d;
    end
  end

  assign stall        = stall_q;
  assign mem_wr_cnt   = mem_cnt_q;
  assign curr_wr_cnt  = curr_cnt_q;
  assign st_if.wr_en  = wr_en_q;
  assign {st_if.wr_sel, st_if.wr_addr, st_if.wr_x0, st_if.wr_x1, st_if.wr_x2,
          st_if.wr_info} = wr_q;
endmodule
